// File: rtl/fetch_stage.sv
// Instruction fetch stage: synchronous instruction memory, one-deep read pipeline and
// a 2-entry skid FIFO toward decode, with PC advance gated on buffer space.
module fetch_stage #(
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned INSTR_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc,
    output logic               pc_advance,
    input  logic               flush,
    input  logic               imem_we,
    input  logic [ADDR_W-1:0]  imem_waddr,
    input  logic [INSTR_W-1:0] imem_wdata,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_addr,
    output logic               instr_valid,
    input  logic               instr_ready
);

    logic [INSTR_W-1:0] mem [2**ADDR_W];
    logic [INSTR_W-1:0] rdata;

    logic               inflight;
    logic [ADDR_W-1:0]  inflight_addr;

    logic [INSTR_W-1:0] buf_instr [2];
    logic [ADDR_W-1:0]  buf_addr  [2];
    logic [1:0]         count;

    logic [1:0]         occ;
    logic               pop;
    logic               push;
    logic               issue;

    always_comb begin
        instr_valid = (count != 2'd0);
        instr       = buf_instr[0];
        instr_addr  = buf_addr[0];
        occ         = count + {1'b0, inflight};
        pop         = instr_valid & instr_ready;
        push        = inflight & ~flush;
        // Only issue when the read will find a FIFO slot on arrival.
        issue       = reset & ~flush & ((occ < 2'd2) | ((occ == 2'd2) & pop));
        pc_advance  = issue;
    end

    // Memory is not reset; read-before-write gives old data on a same-address collision.
    always_ff @(posedge clk) begin
        if (imem_we)
            mem[imem_waddr] <= imem_wdata;
        if (issue)
            rdata <= mem[pc];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count         <= '0;
            inflight      <= 1'b0;
            inflight_addr <= '0;
            buf_instr[0]  <= '0;
            buf_instr[1]  <= '0;
            buf_addr[0]   <= '0;
            buf_addr[1]   <= '0;
        end else begin
            inflight <= issue;
            if (issue)
                inflight_addr <= pc;

            if (flush) begin
                count <= '0;
            end else begin
                case ({push, pop})
                    2'b10: begin
                        buf_instr[count[0]] <= rdata;
                        buf_addr[count[0]]  <= inflight_addr;
                        count               <= count + 2'd1;
                    end
                    2'b01: begin
                        buf_instr[0] <= buf_instr[1];
                        buf_addr[0]  <= buf_addr[1];
                        count        <= count - 2'd1;
                    end
                    2'b11: begin
                        // Head leaves and the arriving word lands right behind the survivor.
                        if (count == 2'd1) begin
                            buf_instr[0] <= rdata;
                            buf_addr[0]  <= inflight_addr;
                        end else begin
                            buf_instr[0] <= buf_instr[1];
                            buf_addr[0]  <= buf_addr[1];
                            buf_instr[1] <= rdata;
                            buf_addr[1]  <= inflight_addr;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a PC model and shadow memory queue expected
// {instr, addr, arrival cycle} on every issue and compare the FIFO head each cycle.
module tb_fetch_stage;

    localparam int unsigned ADDR_W  = 6;
    localparam int unsigned INSTR_W = 16;

    logic               clk;
    logic               reset;
    logic [ADDR_W-1:0]  pc;
    logic               pc_advance;
    logic               flush;
    logic               imem_we;
    logic [ADDR_W-1:0]  imem_waddr;
    logic [INSTR_W-1:0] imem_wdata;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_addr;
    logic               instr_valid;
    logic               instr_ready;

    fetch_stage #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .pc_advance  (pc_advance),
        .flush       (flush),
        .imem_we     (imem_we),
        .imem_waddr  (imem_waddr),
        .imem_wdata  (imem_wdata),
        .instr       (instr),
        .instr_addr  (instr_addr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  addr;
        int                 rdy;
    } entry_t;

    entry_t             q[$];
    logic [INSTR_W-1:0] mem_m [2**ADDR_W];
    int                 cyc;
    int                 n_checks;
    int                 n_fail;

    logic               s_adv;
    logic               s_valid;
    logic [INSTR_W-1:0] s_instr;
    logic [ADDR_W-1:0]  s_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: check mid-cycle, advance the models at the edge, update pc just after it.
    task automatic tick();
        logic   exp_valid;
        logic   exp_pop;
        logic   exp_adv;
        entry_t e;
        @(negedge clk);
        exp_valid = reset && (q.size() > 0) && (q[0].rdy <= cyc);
        exp_pop   = exp_valid && instr_ready;
        exp_adv   = reset && !flush && ((q.size() < 2) || ((q.size() == 2) && exp_pop));
        check("instr_valid", 32'(instr_valid), 32'(exp_valid));
        check("pc_advance", 32'(pc_advance), 32'(exp_adv));
        if (exp_valid) begin
            check("instr", 32'(instr), 32'(q[0].instr));
            check("instr_addr", 32'(instr_addr), 32'(q[0].addr));
        end
        s_adv   = pc_advance;
        s_valid = instr_valid;
        s_instr = instr;
        s_addr  = instr_addr;
        @(posedge clk);
        if (!reset) begin
            q.delete();
        end else begin
            if (exp_pop)
                void'(q.pop_front());
            if (flush)
                q.delete();
            if (exp_adv) begin
                e.instr = mem_m[pc];
                e.addr  = pc;
                e.rdy   = cyc + 2;
                q.push_back(e);
            end
        end
        if (imem_we)
            mem_m[imem_waddr] = imem_wdata;
        cyc++;
        #1;
        if (exp_adv)
            pc = pc + 1'b1;
    endtask

    task automatic do_flush(input logic [ADDR_W-1:0] new_pc);
        flush = 1'b1;
        pc    = new_pc;
        tick();
        check("adv_in_flush", 32'(s_adv), 32'd0);
        flush = 1'b0;
    endtask

    int adv_cnt;

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        cyc         = 0;
        reset       = 1'b0;
        pc          = '0;
        flush       = 1'b0;
        imem_we     = 1'b0;
        imem_waddr  = '0;
        imem_wdata  = '0;
        instr_ready = 1'b0;
        #1;
        check("reset_valid", 32'(instr_valid), 32'd0);
        check("reset_instr", 32'(instr), 32'd0);
        check("reset_addr", 32'(instr_addr), 32'd0);
        check("reset_adv", 32'(pc_advance), 32'd0);

        // Preload memory while held in reset.
        for (int i = 0; i < 64; i++) begin
            imem_we    = 1'b1;
            imem_waddr = ADDR_W'(i);
            if (i == 5)
                imem_wdata = 16'h5555;
            else if (i == 63)
                imem_wdata = 16'hBEEF;
            else
                imem_wdata = 16'(16'h1000 + i);
            tick();
        end
        imem_we = 1'b0;

        // Streaming from reset release.
        reset       = 1'b1;
        instr_ready = 1'b1;
        pc          = '0;
        adv_cnt     = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 0)
                check("t1_first_adv", 32'(s_adv), 32'd1);
            if (i >= 2 && i < 6) begin
                check("t1_instr", 32'(s_instr), 32'(16'h1000 + i - 2));
                check("t1_addr", 32'(s_addr), 32'(i - 2));
            end
            adv_cnt += int'(s_adv);
        end
        check("t1_adv_count", 32'(adv_cnt), 32'd8);

        // Stall from the start, then drain.
        instr_ready = 1'b0;
        do_flush('0);
        adv_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            adv_cnt += int'(s_adv);
        end
        check("t2_stall_adv", 32'(adv_cnt), 32'd2);
        check("t2_hold", 32'(s_instr), 32'h1000);
        instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_drain", 32'(s_instr), 32'(16'h1000 + i));
        end
        instr_ready = 1'b0;
        tick();

        // Flush with buffered and in-flight words, redirect to 8.
        instr_ready = 1'b1;
        do_flush(6'd8);
        tick();
        check("t3_valid_after", 32'(s_valid), 32'd0);
        tick();
        tick();
        check("t3_first_valid", 32'(s_valid), 32'd1);
        check("t3_first_addr", 32'(s_addr), 32'd8);

        // Address wrap-around.
        do_flush(6'd62);
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 3) begin
                check("t4_wrap_addr", 32'(s_addr), 32'd63);
                check("t4_wrap_instr", 32'(s_instr), 32'hBEEF);
            end
            if (i == 4)
                check("t4_wrap_zero", 32'(s_addr), 32'd0);
        end

        // Asynchronous reset mid-cycle while instr_valid is high.
        check("t5_pre_valid", 32'(instr_valid), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("t5_async_valid", 32'(instr_valid), 32'd0);
        check("t5_async_adv", 32'(pc_advance), 32'd0);
        check("t5_async_instr", 32'(instr), 32'd0);
        check("t5_async_addr", 32'(instr_addr), 32'd0);
        tick();
        tick();
        reset = 1'b1;
        pc    = '0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 2)
                check("t5_mem_kept", 32'(s_instr), 32'h1000);
        end

        // Same-cycle write and read of address 5 returns old data.
        do_flush(6'd5);
        imem_we    = 1'b1;
        imem_waddr = 6'd5;
        imem_wdata = 16'hAAAA;
        tick();
        imem_we = 1'b0;
        tick();
        tick();
        check("t6_old_data", 32'(s_instr), 32'h5555);
        check("t6_old_addr", 32'(s_addr), 32'd5);
        tick();
        do_flush(6'd5);
        tick();
        tick();
        tick();
        check("t6_new_data", 32'(s_instr), 32'hAAAA);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
